tx_lane_scheduler: RTL and testbench

TX_LANE_SCHEDULER -- requirements
Module: tx_lane_scheduler

---
 rtl/tx_lane_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_tx_lane_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_lane_scheduler.sv
// tx_lane_scheduler: two requester byte FIFOs merged onto one lane by a
// round-robin scheduler, after INIT_CYCLES idle cycles following reset.
// Ports:
//   clk_2f, reset          clock, async active-high reset
//   data_in0/1, valid_in0/1 requester bytes and push strobes
//   pause                  downstream hold, blocks pops
//   full0/1, overflow0/1   FIFO full flags, sticky dropped-push flags
//   data_out, valid_out    registered scheduled byte and its qualifier
//   grant                  registered one-hot source of data_out
//   active                 scheduler in ACTIVE state
// Build option: TX_IDLE_COM_EN selects 8'hBC (COM) as the idle byte
// instead of 8'h00.
module tx_lane_scheduler #(
    parameter int DEPTH       = 4,
    parameter int INIT_CYCLES = 8
) (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       pause,
    output logic       full0,
    output logic       full1,
    output logic       overflow0,
    output logic       overflow1,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] grant,
    output logic       active
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

`ifdef TX_IDLE_COM_EN
    localparam logic [7:0] IDLE_SYM = 8'hBC;
`else
    localparam logic [7:0] IDLE_SYM = 8'h00;
`endif

    typedef enum logic [1:0] {
        S_INIT,
        S_ACTIVE,
        S_PAUSED
    } state_t;

    state_t        state;
    logic [IW-1:0] init_cnt;
    // 1 = requester 1 was granted last, so requester 0 wins next tie
    logic          last_grant;

    logic [7:0]    mem0 [DEPTH];
    logic [7:0]    mem1 [DEPTH];
    logic [AW-1:0] wptr0, rptr0, wptr1, rptr1;
    logic [CW-1:0] cnt0, cnt1;

    logic push0, push1, pop0, pop1;
    logic ne0, ne1, can_pop;

    assign full0 = (cnt0 == FULL_CNT);
    assign full1 = (cnt1 == FULL_CNT);

    // full is judged on the pre-pop count, so a push racing a pop on a
    // full FIFO is dropped
    assign push0 = valid_in0 & ~full0;
    assign push1 = valid_in1 & ~full1;

    assign ne0     = (cnt0 != '0);
    assign ne1     = (cnt1 != '0);
    assign can_pop = (state == S_ACTIVE) && !pause;

    assign pop0 = can_pop && ne0 && (!ne1 || last_grant);
    assign pop1 = can_pop && ne1 && (!ne0 || !last_grant);

    always_ff @(posedge clk_2f) begin
        if (push0) mem0[wptr0] <= data_in0;
        if (push1) mem1[wptr1] <= data_in1;
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            wptr0 <= '0;
            rptr0 <= '0;
            cnt0  <= '0;
        end else begin
            if (push0) wptr0 <= wptr0 + 1'b1;
            if (pop0)  rptr0 <= rptr0 + 1'b1;
            if (push0 && !pop0)
                cnt0 <= cnt0 + 1'b1;
            else if (!push0 && pop0)
                cnt0 <= cnt0 - 1'b1;
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            wptr1 <= '0;
            rptr1 <= '0;
            cnt1  <= '0;
        end else begin
            if (push1) wptr1 <= wptr1 + 1'b1;
            if (pop1)  rptr1 <= rptr1 + 1'b1;
            if (push1 && !pop1)
                cnt1 <= cnt1 + 1'b1;
            else if (!push1 && pop1)
                cnt1 <= cnt1 - 1'b1;
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            overflow0 <= 1'b0;
            overflow1 <= 1'b0;
        end else begin
            if (valid_in0 && full0) overflow0 <= 1'b1;
            if (valid_in1 && full1) overflow1 <= 1'b1;
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            last_grant <= 1'b1;
            active     <= 1'b0;
            data_out   <= IDLE_SYM;
            valid_out  <= 1'b0;
            grant      <= 2'b00;
        end else begin
            unique case (state)
                S_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state  <= S_ACTIVE;
                        active <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (pause) begin
                        state  <= S_PAUSED;
                        active <= 1'b0;
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state  <= S_ACTIVE;
                        active <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_INIT;
                    init_cnt <= '0;
                    active   <= 1'b0;
                end
            endcase

            if (pop0) begin
                data_out   <= mem0[rptr0];
                valid_out  <= 1'b1;
                grant      <= 2'b01;
                last_grant <= 1'b0;
            end else if (pop1) begin
                data_out   <= mem1[rptr1];
                valid_out  <= 1'b1;
                grant      <= 2'b10;
                last_grant <= 1'b1;
            end else begin
                data_out  <= IDLE_SYM;
                valid_out <= 1'b0;
                grant     <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// tb_tx_lane_scheduler: self-checking bench for tx_lane_scheduler.
// Expected bytes go to a queue when pushed and are matched as they leave.
module tb_tx_lane_scheduler;

    localparam int DEPTH       = 4;
    localparam int INIT_CYCLES = 8;

`ifdef TX_IDLE_COM_EN
    localparam logic [7:0] IDLE = 8'hBC;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif

    logic       clk_2f = 1'b0;
    logic       reset;
    logic [7:0] data_in0, data_in1;
    logic       valid_in0, valid_in1;
    logic       pause;
    logic       full0, full1, overflow0, overflow1;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] grant;
    logic       active;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    bit         mon_en = 1'b0;

    typedef struct {
        bit         req;
        logic [7:0] data;
        logic [1:0] grant;
    } vec_t;

    vec_t vecs[4];

    tx_lane_scheduler #(
        .DEPTH      (DEPTH),
        .INIT_CYCLES(INIT_CYCLES)
    ) dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .data_in0 (data_in0),
        .data_in1 (data_in1),
        .valid_in0(valid_in0),
        .valid_in1(valid_in1),
        .pause    (pause),
        .full0    (full0),
        .full1    (full1),
        .overflow0(overflow0),
        .overflow1(overflow1),
        .data_out (data_out),
        .valid_out(valid_out),
        .grant    (grant),
        .active   (active)
    );

    initial forever #5 clk_2f = ~clk_2f;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_2f);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        pause     = 1'b0;
        repeat (2) @(posedge clk_2f);
        #1;
        reset = 1'b0;
    endtask

    // Counts edges after reset release until active rises.
    task automatic wait_active(input string name);
        int k = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (active && k == 0) k = i;
        end
        chk(name, k, INIT_CYCLES);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push_req(input bit req, input logic [7:0] d);
        if (req) begin
            valid_in1 = 1'b1;
            data_in1  = d;
        end else begin
            valid_in0 = 1'b1;
            data_in0  = d;
        end
    endtask

    always @(negedge clk_2f) begin
        if (mon_en) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", valid_out, 0);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    chk("sb_grant", grant, e[9:8]);
                    chk("sb_data", data_out, e[7:0]);
                end
            end else begin
                chk("idle_data", data_out, IDLE);
                chk("idle_grant", grant, 0);
            end
        end
    end

    initial begin
        vecs[0] = '{1'b0, 8'hA1, 2'b01};
        vecs[1] = '{1'b1, 8'h5A, 2'b10};
        vecs[2] = '{1'b0, 8'hFF, 2'b01};
        vecs[3] = '{1'b1, 8'h00, 2'b10};

        data_in0  = 8'h00;
        data_in1  = 8'h00;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        pause     = 1'b0;
        reset     = 1'b1;

        // Asynchronous reset values, before any clock edge
        #2;
        chk("rst_valid", valid_out, 0);
        chk("rst_grant", grant, 0);
        chk("rst_data", data_out, IDLE);
        chk("rst_active", active, 0);
        chk("rst_full", {full1, full0}, 0);
        chk("rst_ovf", {overflow1, overflow0}, 0);
        mon_en = 1'b1;

        // Idle INIT length
        do_reset();
        wait_active("init_len");

        // Single pushes while ACTIVE: one-cycle latency, one beat
        for (int i = 0; i < 4; i++) begin
            push_req(vecs[i].req, vecs[i].data);
            exp_q.push_back({vecs[i].grant, vecs[i].data});
            tick();
            valid_in0 = 1'b0;
            valid_in1 = 1'b0;
            tick();
            chk("lat_valid", valid_out, 1);
            chk("lat_data", data_out, vecs[i].data);
            chk("lat_grant", grant, vecs[i].grant);
            tick();
            chk("lat_drop", valid_out, 0);
        end
        wait_drain("lat_drain");

        // Preload both during INIT: round-robin starting at req0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_req(1'b0, 8'h10 + 8'(i));
            push_req(1'b1, 8'h20 + 8'(i));
            tick();
        end
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({2'b01, 8'h10 + 8'(i)});
            exp_q.push_back({2'b10, 8'h20 + 8'(i)});
        end
        chk("rr_no_early", valid_out, 0);
        wait_drain("rr_drain");
        chk("rr_ovf", {overflow1, overflow0}, 0);

        // Overflow on req0 during INIT
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_req(1'b0, 8'h31 + 8'(i));
            tick();
            if (i == 3) begin
                chk("ovf_full4", full0, 1);
                chk("ovf_clear4", overflow0, 0);
            end
        end
        valid_in0 = 1'b0;
        chk("ovf_set5", overflow0, 1);
        chk("ovf_other", overflow1, 0);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({2'b01, 8'h31 + 8'(i)});
        wait_drain("ovf_drain");
        tick();
        chk("ovf_sticky", overflow0, 1);
        chk("ovf_empty", full0, 0);

        // Pause for 4 cycles with req1 filling up
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) push_req(1'b1, 8'h41 + 8'(i));
            else valid_in1 = 1'b0;
            tick();
            chk("pause_hold", valid_out, 0);
        end
        for (int i = 0; i < 3; i++)
            exp_q.push_back({2'b10, 8'h41 + 8'(i)});
        chk("pause_inactive", active, 0);
        pause = 1'b0;
        tick();
        chk("unpause_gap", valid_out, 0);
        chk("unpause_active", active, 1);
        tick();
        chk("resume_valid", valid_out, 1);
        chk("resume_data", data_out, 8'h41);
        wait_drain("pause_drain");

        // Reset in the middle of a stream
        pause = 1'b1;
        push_req(1'b0, 8'h51);
        push_req(1'b1, 8'h61);
        tick();
        push_req(1'b0, 8'h52);
        push_req(1'b1, 8'h62);
        tick();
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        pause     = 1'b0;
        tick();
        mon_en = 1'b0;
        tick();
        chk("mid_valid", valid_out, 1);
        chk("mid_data", data_out, 8'h51);
        chk("mid_grant", grant, 2'b01);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_data", data_out, IDLE);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_full", {full1, full0}, 0);
        mon_en = 1'b1;
        repeat (2) @(posedge clk_2f);
        #1;
        reset = 1'b0;
        wait_active("mid_init_len");
        repeat (5) tick();
        chk("mid_no_leak", valid_out, 0);

        chk("final_queue", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
